// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART frame parser: FSM states, frame delimiters,
// command codes and helper functions used to validate LEN and SET_SIZE payloads.
package uart_frame_parser_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_CMD = 3'd1,
        GET_LEN = 3'd2,
        PAYLOAD = 3'd3,
        DISCARD = 3'd4,
        GET_EOF = 3'd5
    } state_t;

    localparam logic [7:0] SOF_BYTE     = 8'hFE;
    localparam logic [7:0] EOF_BYTE     = 8'hEF;

    localparam logic [7:0] CMD_SET_SIZE = 8'h01;
    localparam logic [7:0] CMD_CLEAR    = 8'h02;
    localparam logic [7:0] CMD_MATRIX   = 8'h03;
    localparam logic [7:0] CMD_VECTOR   = 8'h04;
    localparam logic [7:0] CMD_START    = 8'h05;

    localparam logic [3:0] MAX_N        = 4'd8;

    // True for the five command codes the parser understands.
    function automatic logic cmd_known(input logic [7:0] cmd);
        logic known;
        case (cmd)
            CMD_SET_SIZE, CMD_CLEAR, CMD_MATRIX, CMD_VECTOR, CMD_START: known = 1'b1;
            default:                                                   known = 1'b0;
        endcase
        return known;
    endfunction

    // True when LEN is the length this command requires for the stored size N.
    // A MATRIX or VECTOR frame with no size configured is always rejected.
    function automatic logic len_ok(input logic [7:0] cmd, input logic [3:0] n, input logic [7:0] len);
        logic [6:0] nn;
        logic       ok;
        nn = 7'(n) * 7'(n);
        case (cmd)
            CMD_SET_SIZE: ok = (len == 8'd1);
            CMD_CLEAR:    ok = (len == 8'd0);
            CMD_START:    ok = (len == 8'd0);
            CMD_MATRIX:   ok = (n != 4'd0) && (len == {1'b0, nn});
            CMD_VECTOR:   ok = (n != 4'd0) && (len == {4'd0, n});
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // True for a legal matrix size 1..MAX_N.
    function automatic logic size_ok(input logic [7:0] value);
        return (value != 8'd0) && (value <= {4'd0, MAX_N});
    endfunction

endpackage

// File: rtl/uart_frame_parser_timer.sv
// Idle-cycle watchdog for an open frame. The count restarts on every kick
// (received byte) and while the parser is idle; expired asserts in the cycle
// that completes TIMEOUT_CYC consecutive idle cycles.
module rx_timeout_timer #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic kick,
    input  logic run,
    output logic expired
);

    localparam int             CW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count_r;

    // Idle-cycle counter, saturating at LIMIT until kicked or stopped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
        end else if (kick || !run) begin
            count_r <= '0;
        end else if (count_r != LIMIT) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = run && (count_r == LIMIT);

endmodule

// File: rtl/uart_frame_parser.sv
// Byte-stream frame parser sitting behind a UART receiver. Decodes
// SOF/CMD/LEN/payload/EOF frames, forwards matrix/vector/size bytes with
// one-cycle strobes, and raises a sticky error flag on malformed frames,
// receiver errors or mid-frame stalls.
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic [7:0] rec_data,
    output logic       size_m_en,
    output logic       enable_mat,
    output logic       enable_vec,
    output logic       enb_assign,
    output logic       clear,
    output logic       start,
    output logic       frame_err,
    output logic       busy
);

    state_t     state_r, state_n;
    logic [7:0] cmd_r, cmd_n;
    logic [3:0] n_r, n_n;
    logic [7:0] len_r, len_n;
    logic [7:0] rec_data_r, rec_n;
    logic       frame_err_r, err_n;
    logic       size_r, size_n;
    logic       mat_r, mat_n;
    logic       vec_r, vec_n;
    logic       clr_r, clr_n;
    logic       sta_r, sta_n;
    logic       enb_r, enb_n;
    logic       busy_r, busy_n;
    logic       expired_s;

    rx_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .kick    (rx_valid),
        .run     (state_r != IDLE),
        .expired (expired_s)
    );

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            cmd_r       <= 8'd0;
            n_r         <= 4'd0;
            len_r       <= 8'd0;
            rec_data_r  <= 8'd0;
            frame_err_r <= 1'b0;
            size_r      <= 1'b0;
            mat_r       <= 1'b0;
            vec_r       <= 1'b0;
            clr_r       <= 1'b0;
            sta_r       <= 1'b0;
            enb_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            cmd_r       <= cmd_n;
            n_r         <= n_n;
            len_r       <= len_n;
            rec_data_r  <= rec_n;
            frame_err_r <= err_n;
            size_r      <= size_n;
            mat_r       <= mat_n;
            vec_r       <= vec_n;
            clr_r       <= clr_n;
            sta_r       <= sta_n;
            enb_r       <= enb_n;
            busy_r      <= busy_n;
        end
    end

    // Next-state and next-output decode. Receiver error beats a byte, a byte beats timeout.
    always_comb begin
        state_n = state_r;
        cmd_n   = cmd_r;
        n_n     = n_r;
        len_n   = len_r;
        rec_n   = rec_data_r;
        err_n   = frame_err_r;
        size_n  = 1'b0;
        mat_n   = 1'b0;
        vec_n   = 1'b0;
        clr_n   = 1'b0;
        sta_n   = 1'b0;

        if ((state_r != IDLE) && rx_err) begin
            err_n   = 1'b1;
            state_n = IDLE;
        end else if (rx_valid) begin
            case (state_r)
                IDLE: begin
                    if (rx_data == SOF_BYTE) begin
                        state_n = GET_CMD;
                        err_n   = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
                GET_CMD: begin
                    if (cmd_known(rx_data)) begin
                        cmd_n   = rx_data;
                        state_n = GET_LEN;
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
                GET_LEN: begin
                    len_n = rx_data;
                    if (len_ok(cmd_r, n_r, rx_data)) begin
                        state_n = (rx_data == 8'd0) ? GET_EOF : PAYLOAD;
                    end else begin
                        err_n   = 1'b1;
                        state_n = (rx_data == 8'd0) ? GET_EOF : DISCARD;
                    end
                end
                PAYLOAD: begin
                    len_n   = len_r - 8'd1;
                    state_n = (len_r == 8'd1) ? GET_EOF : PAYLOAD;
                    case (cmd_r)
                        CMD_MATRIX: begin
                            rec_n = rx_data;
                            mat_n = 1'b1;
                        end
                        CMD_VECTOR: begin
                            rec_n = rx_data;
                            vec_n = 1'b1;
                        end
                        CMD_SET_SIZE: begin
                            if (size_ok(rx_data)) begin
                                n_n    = rx_data[3:0];
                                rec_n  = rx_data;
                                size_n = 1'b1;
                            end else begin
                                err_n  = 1'b1;
                            end
                        end
                        default: begin
                            rec_n = rec_data_r;
                        end
                    endcase
                end
                DISCARD: begin
                    len_n   = len_r - 8'd1;
                    state_n = (len_r == 8'd1) ? GET_EOF : DISCARD;
                end
                GET_EOF: begin
                    state_n = IDLE;
                    if (rx_data == EOF_BYTE) begin
                        case (cmd_r)
                            CMD_CLEAR: begin
                                clr_n = 1'b1;
                                n_n   = 4'd0;
                            end
                            CMD_START: sta_n = 1'b1;
                            default:   sta_n = 1'b0;
                        endcase
                    end else begin
                        err_n = 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end else if ((state_r != IDLE) && expired_s) begin
            err_n   = 1'b1;
            state_n = IDLE;
        end else begin
            state_n = state_r;
        end

        enb_n  = (state_n == PAYLOAD) && ((cmd_n == CMD_MATRIX) || (cmd_n == CMD_VECTOR));
        busy_n = (state_n != IDLE);
    end

    assign rec_data   = rec_data_r;
    assign size_m_en  = size_r;
    assign enable_mat = mat_r;
    assign enable_vec = vec_r;
    assign enb_assign = enb_r;
    assign clear      = clr_r;
    assign start      = sta_r;
    assign frame_err  = frame_err_r;
    assign busy       = busy_r;

endmodule
